// File: rtl/shared_reg_arbiter_if.sv
// shared_reg_arbiter_if: request/grant/data bundle between requesters and the shared-register arbiter (lock only with SHARED_REG_ARB_LOCK_EN)
interface shared_reg_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    localparam int IDX_W = $clog2(N_REQ);
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] wdata;
`ifdef SHARED_REG_ARB_LOCK_EN
    logic [N_REQ-1:0]       lock;
`endif
    logic [N_REQ-1:0]       gnt;
    logic                   ack;
    logic [WIDTH-1:0]       q;
    logic [IDX_W-1:0]       owner;
    logic                   busy;
    logic [CNT_W-1:0]       write_cnt;

    modport master (
        output req, output wdata,
`ifdef SHARED_REG_ARB_LOCK_EN
        output lock,
`endif
        input gnt, input ack, input q, input owner, input busy, input write_cnt
    );

    modport slave (
        input req, input wdata,
`ifdef SHARED_REG_ARB_LOCK_EN
        input lock,
`endif
        output gnt, output ack, output q, output owner, output busy, output write_cnt
    );
endinterface

// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter: round-robin arbiter committing one requester's data into a shared register; SHARED_REG_ARB_LOCK_EN adds priority lock
module shared_reg_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input logic                clk,
    input logic                rst_n,
    shared_reg_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, GRANT, COMMIT} state_t;

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [IDX_W-1:0]   win_q, win_d, ptr_q, ptr_d, owner_q, owner_d;
    logic [IDX_W-1:0]   rr_win, win_inc, ptr_commit;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // First requester found scanning upward from p, wrapping modulo N_REQ
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r, input logic [IDX_W-1:0] p);
        rr_pick = '0;
        for (int k = N_REQ - 1; k >= 0; k--)
            if (r[(int'(p) + k) % N_REQ]) rr_pick = IDX_W'((int'(p) + k) % N_REQ);
    endfunction

    assign rr_win  = rr_pick(bus.req, ptr_q);
    assign win_inc = (win_q == IDX_W'(N_REQ - 1)) ? '0 : win_q + IDX_W'(1);
`ifdef SHARED_REG_ARB_LOCK_EN
    assign ptr_commit = bus.lock[win_q] ? win_q : win_inc;
`else
    assign ptr_commit = win_inc;
`endif

    // Next-state: arbitrate in IDLE, commit or abort at the end of GRANT, one bubble in COMMIT
    always_comb begin
        state_d = state_q;
        gnt_d   = '0;
        win_d   = win_q;
        ptr_d   = ptr_q;
        q_d     = q_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (|bus.req) begin
                win_d   = rr_win;
                gnt_d   = N_REQ'(1) << rr_win;
                state_d = GRANT;
            end
            GRANT: if (bus.req[win_q]) begin
                q_d     = bus.wdata[win_q*WIDTH +: WIDTH];
                owner_d = win_q;
                cnt_d   = cnt_q + CNT_W'(1);
                ptr_d   = ptr_commit;
                state_d = COMMIT;
            end else begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; async reset drops any in-flight grant without committing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            win_q   <= '0;
            ptr_q   <= '0;
            q_q     <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            win_q   <= win_d;
            ptr_q   <= ptr_d;
            q_q     <= q_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.ack       = (state_q == COMMIT);
    assign bus.busy      = (state_q != IDLE);
    assign bus.q         = q_q;
    assign bus.owner     = owner_q;
    assign bus.write_cnt = cnt_q;
endmodule

// File: tb/tb_shared_reg_arbiter.sv
// tb_shared_reg_arbiter: vector table, corner-case sequences and randomized reference-model check of shared_reg_arbiter
module tb_shared_reg_arbiter;
    localparam int N = 4;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    shared_reg_arbiter_if #(.N_REQ(N), .WIDTH(W), .CNT_W(16)) bif ();
    shared_reg_arbiter_if #(.N_REQ(N), .WIDTH(W), .CNT_W(4))  sif ();

    shared_reg_arbiter #(.N_REQ(N), .WIDTH(W), .CNT_W(16)) dut   (.clk(clk), .rst_n(rst_n), .bus(bif));
    shared_reg_arbiter #(.N_REQ(N), .WIDTH(W), .CNT_W(4))  dut_w (.clk(clk), .rst_n(rst_n), .bus(sif));

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  gnt;
        logic [7:0]  q;
        logic [1:0]  owner;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_gnt"}, 32'(bif.gnt), 0);
        chk({tag, "_ack"}, 32'(bif.ack), 0);
        chk({tag, "_q"}, 32'(bif.q), 0);
        chk({tag, "_owner"}, 32'(bif.owner), 0);
        chk({tag, "_busy"}, 32'(bif.busy), 0);
        chk({tag, "_cnt"}, 32'(bif.write_cnt), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bif.req = '0;
        sif.req = '0;
`ifdef SHARED_REG_ARB_LOCK_EN
        bif.lock = '0;
        sif.lock = '0;
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic do_txn(input logic [3:0] r, input logic [3:0] eg, input logic [7:0] eq,
                          input logic [1:0] eo, input logic [15:0] ec);
        bif.req = r;
        @(negedge clk);
        chk("txn_gnt", 32'(bif.gnt), 32'(eg));
        chk("txn_busy", 32'(bif.busy), 1);
        chk("txn_ack_early", 32'(bif.ack), 0);
        @(negedge clk);
        chk("txn_ack", 32'(bif.ack), 1);
        chk("txn_gnt_clr", 32'(bif.gnt), 0);
        chk("txn_q", 32'(bif.q), 32'(eq));
        chk("txn_owner", 32'(bif.owner), 32'(eo));
        chk("txn_cnt", 32'(bif.write_cnt), 32'(ec));
        bif.req = '0;
        @(negedge clk);
        chk("txn_idle", 32'(bif.busy), 0);
    endtask

    // Reference model: transaction-level view of the arbiter
    int m_phase, m_win, m_ptr, m_owner;
    logic [7:0]  m_q;
    logic [15:0] m_cnt;

    initial begin
        logic [3:0] r, lk;
        int acks;
        bif.req = '0;
        bif.wdata = 32'h13A5_1110;
        sif.req = '0;
        sif.wdata = 32'h4433_2211;
`ifdef SHARED_REG_ARB_LOCK_EN
        bif.lock = '0;
        sif.lock = '0;
`endif
        tbl[0] = '{4'b0100, 4'b0100, 8'hA5, 2'd2, 16'd1};
        tbl[1] = '{4'b1111, 4'b1000, 8'h13, 2'd3, 16'd2};
        tbl[2] = '{4'b0110, 4'b0010, 8'h11, 2'd1, 16'd3};
        tbl[3] = '{4'b0011, 4'b0001, 8'h10, 2'd0, 16'd4};
        tbl[4] = '{4'b1001, 4'b1000, 8'h13, 2'd3, 16'd5};
        tbl[5] = '{4'b1000, 4'b1000, 8'h13, 2'd3, 16'd6};

        #2 chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_busy", 32'(bif.busy), 0);
            chk("idle_gnt", 32'(bif.gnt), 0);
        end

        for (int i = 0; i < 6; i++)
            do_txn(tbl[i].req, tbl[i].gnt, tbl[i].q, tbl[i].owner, tbl[i].cnt);

        // Fairness with everyone requesting
        do_reset();
        bif.wdata = 32'h1312_1110;
        bif.req = 4'hF;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            chk("fair_ack", 32'(bif.ack), 32'(c % 3 == 2));
            if (c % 3 == 1) chk("fair_gnt", 32'(bif.gnt), 32'(1 << ((c / 3) % 4)));
            if (c % 3 == 2) begin
                chk("fair_owner", 32'(bif.owner), 32'((c / 3) % 4));
                chk("fair_q", 32'(bif.q), 32'(8'h10 + (c / 3) % 4));
                chk("fair_cnt", 32'(bif.write_cnt), 32'(c / 3 + 1));
            end
        end
        bif.req = '0;
        @(negedge clk);

        // Abort keeps ptr, q and count
        do_reset();
        do_txn(4'b0001, 4'b0001, 8'h10, 2'd0, 16'd1);
        bif.req = 4'b1000;
        @(negedge clk);
        chk("abort_gnt", 32'(bif.gnt), 32'b1000);
        bif.req = '0;
        @(negedge clk);
        chk("abort_ack", 32'(bif.ack), 0);
        chk("abort_busy", 32'(bif.busy), 0);
        chk("abort_q", 32'(bif.q), 32'h10);
        chk("abort_cnt", 32'(bif.write_cnt), 1);
        do_txn(4'b1111, 4'b0010, 8'h11, 2'd1, 16'd2);

        // Asynchronous reset in the middle of COMMIT
        bif.req = 4'b0100;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_pre_ack", 32'(bif.ack), 1);
        #2 rst_n = 1'b0;
        #1 chk_zero("midrst");
        bif.req = '0;
        @(negedge clk);
        rst_n = 1'b1;

`ifdef SHARED_REG_ARB_LOCK_EN
        do_reset();
        bif.lock = 4'b0001;
        do_txn(4'b0011, 4'b0001, 8'h10, 2'd0, 16'd1);
        do_txn(4'b0011, 4'b0001, 8'h10, 2'd0, 16'd2);
        bif.lock = '0;
        do_txn(4'b0011, 4'b0001, 8'h10, 2'd0, 16'd3);
        do_txn(4'b0011, 4'b0010, 8'h11, 2'd1, 16'd4);
`endif

        // Counter wrap on the narrow-counter instance
        do_reset();
        sif.req = '1;
        acks = 0;
        for (int c = 0; c < 200 && acks < 16; c++) begin
            @(negedge clk);
            if (sif.ack) begin
                acks++;
                if (acks == 15) chk("wrap_full", 32'(sif.write_cnt), 15);
                if (acks == 16) chk("wrap_zero", 32'(sif.write_cnt), 0);
            end
        end
        chk("wrap_acks", 32'(acks), 16);
        sif.req = '0;

        // Randomized run against the reference model
        do_reset();
        m_phase = 0; m_win = 0; m_ptr = 0; m_owner = 0; m_q = '0; m_cnt = '0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            chk("rnd_gnt", 32'(bif.gnt), (m_phase == 1) ? 32'(1 << m_win) : 0);
            chk("rnd_ack", 32'(bif.ack), 32'(m_phase == 2));
            chk("rnd_busy", 32'(bif.busy), 32'(m_phase != 0));
            chk("rnd_q", 32'(bif.q), 32'(m_q));
            chk("rnd_owner", 32'(bif.owner), 32'(m_owner));
            chk("rnd_cnt", 32'(bif.write_cnt), 32'(m_cnt));
            if (m_phase == 0) bif.wdata = $urandom;
            r = ($urandom_range(0, 3) == 0) ? 4'b0 : 4'($urandom_range(0, 15));
            if (m_phase == 1 && $urandom_range(0, 7) != 0) r[m_win] = 1'b1;
            bif.req = r;
            lk = 4'($urandom_range(0, 15));
`ifdef SHARED_REG_ARB_LOCK_EN
            bif.lock = lk;
`else
            lk = '0;
`endif
            if (m_phase == 0) begin
                if (r != 0) begin
                    for (int i = N - 1; i >= 0; i--)
                        if (r[(m_ptr + i) % N]) m_win = (m_ptr + i) % N;
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (r[m_win]) begin
                    m_q = bif.wdata[m_win*W +: W];
                    m_owner = m_win;
                    m_cnt = m_cnt + 16'd1;
                    m_ptr = lk[m_win] ? m_win : (m_win + 1) % N;
                    m_phase = 2;
                end else begin
                    m_phase = 0;
                end
            end else begin
                m_phase = 0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
